display_scan_ctrl: RTL

- Time-multiplexed scan controller for the 4-digit 7-segment display.
- Drives the combinational binary-to-decimal digit extractor's select/data/decimal inputs and latches its 4-bit digit output.
- Produces one-hot active-low anode drive, a registered digit code for the segment decoder, and the decimal point.
- Double-buffers host values so a frame is never torn.

---
 rtl/display_scan_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
// Scan controller for a 4-digit 7-segment display driving an external digit extractor.
// Latency: load_ack one cycle after load; new value shown from the frame after the next frame_done.
// Backpressure: none. Loads are always accepted (last wins). en=0 blanks and freezes the scan next cycle.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-low reset
//   en              scan enable; low blanks anodes/dp and holds the slot
//   load, value_in, half_in   host value capture (value saturates at SAT_VALUE)
//   load_ack        one-cycle pulse the cycle after each accepted load
//   ext_sel, ext_data, ext_decimal / ext_digit   handshake-free link to the
//                   combinational digit extractor (select = current slot)
//   seg_digit       registered digit code for the segment decoder
//   anode_n, dp_n   active-low digit enables and decimal point
//   frame_done      one-cycle pulse on the last lit cycle of slot 0
//   overflow        sticky flag: active value was saturated
//
// Optional build macro: LEADING_ZERO_BLANK_EN -- when defined, the tens digit
// (slot 3) stays dark for a whole slot whenever its latched digit is 0.

module display_scan_ctrl #(
    parameter int REFRESH_DIV = 50000,
    parameter int SAT_VALUE   = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] value_in,
    input  logic       half_in,
    output logic       load_ack,
    output logic [1:0] ext_sel,
    output logic [7:0] ext_data,
    output logic       ext_decimal,
    input  logic [3:0] ext_digit,
    output logic [3:0] seg_digit,
    output logic [3:0] anode_n,
    output logic       dp_n,
    output logic       frame_done,
    output logic       overflow
);

    localparam int             CW       = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [7:0]     SAT      = 8'(SAT_VALUE);

    localparam logic [1:0] ST_BLANK = 2'd0;
    localparam logic [1:0] ST_LATCH = 2'd1;
    localparam logic [1:0] ST_ON    = 2'd2;

    // Scan state
    logic [1:0]    state;
    logic [1:0]    slot;
    logic [CW-1:0] cnt;
    logic [3:0]    seg_q;

    logic [1:0]    nxt_state;
    logic [1:0]    nxt_slot;
    logic [CW-1:0] nxt_cnt;
    logic [3:0]    nxt_seg;
    logic [3:0]    nxt_anode_n;
    logic          nxt_dp_n;
    logic          nxt_frame_done;

    // Host value buffers
    logic [7:0] pend_val;
    logic       pend_half;
    logic       pend_ovf;
    logic       pend_vld;
    logic [7:0] act_val;
    logic       act_half;
    logic       act_ovf;
    logic       ack_q;

    logic [7:0] sat_val;
    logic       in_ovf;

    assign in_ovf  = (value_in > SAT);
    assign sat_val = in_ovf ? SAT : value_in;

    // Next-state logic. A low en parks the FSM in BLANK of the current slot
    // so scanning restarts cleanly from that slot when en returns.
    always_comb begin
        nxt_state = state;
        nxt_slot  = slot;
        nxt_cnt   = cnt;
        nxt_seg   = seg_q;
        if (!en) begin
            nxt_state = ST_BLANK;
            nxt_cnt   = '0;
        end else begin
            case (state)
                ST_BLANK: begin
                    nxt_state = ST_LATCH;
                    nxt_cnt   = cnt + CNT_ONE;
                end
                ST_LATCH: begin
                    nxt_state = ST_ON;
                    nxt_cnt   = cnt + CNT_ONE;
                    nxt_seg   = ext_digit;
                end
                ST_ON: begin
                    if (cnt == CNT_LAST) begin
                        nxt_state = ST_BLANK;
                        nxt_cnt   = '0;
                        // 3 -> 2 -> 1 -> 0 -> 3 falls out of 2-bit wrap
                        nxt_slot  = slot - 2'd1;
                    end else begin
                        nxt_cnt = cnt + CNT_ONE;
                    end
                end
                default: begin
                    nxt_state = ST_BLANK;
                    nxt_cnt   = '0;
                end
            endcase
        end
    end

    // Display drive is decoded from the next state and registered, so the
    // anode/dp pins never glitch while the state bits change.
    always_comb begin
        nxt_anode_n    = 4'hF;
        nxt_dp_n       = 1'b1;
        nxt_frame_done = 1'b0;
        if (nxt_state == ST_ON) begin
            nxt_anode_n = ~(4'b0001 << nxt_slot);
`ifdef LEADING_ZERO_BLANK_EN
            if ((nxt_slot == 2'd3) && (nxt_seg == 4'd0)) begin
                nxt_anode_n = 4'hF;
            end
`else
`endif
            nxt_dp_n       = (nxt_slot != 2'd2);
            nxt_frame_done = (nxt_slot == 2'd0) && (nxt_cnt == CNT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_BLANK;
            slot       <= 2'd3;
            cnt        <= '0;
            seg_q      <= 4'd0;
            anode_n    <= 4'hF;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= nxt_state;
            slot       <= nxt_slot;
            cnt        <= nxt_cnt;
            seg_q      <= nxt_seg;
            anode_n    <= nxt_anode_n;
            dp_n       <= nxt_dp_n;
            frame_done <= nxt_frame_done;
        end
    end

    // Double buffer. The active copy only changes on the frame_done cycle, so
    // all four slots of a frame come from the same value. A load landing on
    // that very cycle goes straight to active instead of waiting a frame.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_val  <= 8'd0;
            pend_half <= 1'b0;
            pend_ovf  <= 1'b0;
            pend_vld  <= 1'b0;
            act_val   <= 8'd0;
            act_half  <= 1'b0;
            act_ovf   <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            ack_q <= load;
            if (load) begin
                pend_val  <= sat_val;
                pend_half <= half_in;
                pend_ovf  <= in_ovf;
                pend_vld  <= 1'b1;
            end
            if (frame_done) begin
                if (load) begin
                    act_val  <= sat_val;
                    act_half <= half_in;
                    act_ovf  <= in_ovf;
                    pend_vld <= 1'b0;
                end else if (pend_vld) begin
                    act_val  <= pend_val;
                    act_half <= pend_half;
                    act_ovf  <= pend_ovf;
                    pend_vld <= 1'b0;
                end
            end
        end
    end

    assign load_ack    = ack_q;
    assign ext_sel     = slot;
    assign ext_data    = act_val;
    assign ext_decimal = act_half;
    assign overflow    = act_ovf;
    assign seg_digit   = seg_q;

endmodule
